signature_frame_parser: RTL and testbench

Byte-serial front end for the signature verification path. Accepts a framed byte stream (start-of-frame marker, four record fields, XOR checksum) over a valid/ready handshake. Validates each frame and presents region, auth_level, expiry and signature_id as stable parallel fields with a one-cycle strobe, directly feeding the registered pattern-match stage. Malformed or stalled frames are dropped with an error pulse and never disturb the presented fields.

---
 rtl/signature_frame_parser.sv | 138 +++++++++++++
 tb/tb_signature_frame_parser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/signature_frame_parser.sv
// Byte-serial parser for SOF/region/auth/expiry/sig/XOR-checksum frames; presents validated fields with a strobe.
// Optional statistics counters (good_count, bad_count) are enabled by defining FRAME_STATS_EN.
module signature_frame_parser #(
    parameter logic [7:0]  SOF_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT  = 255
`ifdef FRAME_STATS_EN
    ,
    parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       region,
    output logic [7:0]       auth_level,
    output logic [7:0]       expiry,
    output logic [7:0]       signature_id,
    output logic             fields_valid,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic             busy
`ifdef FRAME_STATS_EN
    ,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count
`endif
);

    typedef enum logic [2:0] {
        IDLE, F_REGION, F_AUTH, F_EXPIRY, F_SIG, F_CKSUM, EMIT
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_tmo_cnt;
    logic [7:0]  r_sh_region, r_sh_auth, r_sh_expiry, r_sh_sig;

    logic       w_xfer;
    logic [7:0] w_cksum;

    assign w_xfer  = in_valid & in_ready;
    assign w_cksum = r_sh_region ^ r_sh_auth ^ r_sh_expiry ^ r_sh_sig;

    // NOTE: all state and registered outputs use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tmo_cnt    <= '0;
            r_sh_region  <= '0;
            r_sh_auth    <= '0;
            r_sh_expiry  <= '0;
            r_sh_sig     <= '0;
            in_ready     <= 1'b1;
            region       <= '0;
            auth_level   <= '0;
            expiry       <= '0;
            signature_id <= '0;
            fields_valid <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= 2'b00;
            busy         <= 1'b0;
        end else begin
            fields_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_xfer && in_data == SOF_BYTE) begin
                        r_state <= F_REGION;
                        busy    <= 1'b1;
                    end
                end
                F_REGION, F_AUTH, F_EXPIRY, F_SIG, F_CKSUM: begin
                    if (w_xfer) begin
                        r_tmo_cnt <= '0;
                        case (r_state)
                            F_REGION: begin r_sh_region <= in_data; r_state <= F_AUTH;   end
                            F_AUTH:   begin r_sh_auth   <= in_data; r_state <= F_EXPIRY; end
                            F_EXPIRY: begin r_sh_expiry <= in_data; r_state <= F_SIG;    end
                            F_SIG:    begin r_sh_sig    <= in_data; r_state <= F_CKSUM;  end
                            default: begin
                                if (in_data == w_cksum) begin
                                    region       <= r_sh_region;
                                    auth_level   <= r_sh_auth;
                                    expiry       <= r_sh_expiry;
                                    signature_id <= r_sh_sig;
                                    fields_valid <= 1'b1;
                                    in_ready     <= 1'b0;
                                    r_state      <= EMIT;
                                end else begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'b01;
                                    busy      <= 1'b0;
                                    r_state   <= IDLE;
                                end
                            end
                        endcase
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        // The stalled frame is abandoned; its shadows are overwritten by the next one.
                        r_tmo_cnt <= '0;
                        frame_err <= 1'b1;
                        err_code  <= 2'b10;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                EMIT: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_count <= '0;
            bad_count  <= '0;
        end else begin
            if (fields_valid && good_count != '1) good_count <= good_count + 1'b1;
            if (frame_err && bad_count != '1)     bad_count  <= bad_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_signature_frame_parser.sv
// Directed bench for signature_frame_parser: cycle vector table plus hand-written timeout/reset sequences.
module tb_signature_frame_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  region, auth_level, expiry, signature_id;
    logic        fields_valid, frame_err, busy;
    logic [1:0]  err_code;
`ifdef FRAME_STATS_EN
    logic [15:0] good_count, bad_count;
`endif

    int checks   = 0;
    int failures = 0;

    signature_frame_parser #(.SOF_BYTE(8'hA5), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .region       (region),
        .auth_level   (auth_level),
        .expiry       (expiry),
        .signature_id (signature_id),
        .fields_valid (fields_valid),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy)
`ifdef FRAME_STATS_EN
        ,
        .good_count   (good_count),
        .bad_count    (bad_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        rdy;
        logic        fv;
        logic        fe;
        logic [1:0]  ec;
        logic        bsy;
        logic [31:0] f;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] F0 = 32'h00000000;
    localparam logic [31:0] FA = 32'h0A0110F3;
    localparam logic [31:0] FB = 32'h11223344;
    localparam logic [31:0] FC = 32'h55667788;
    localparam logic [31:0] FD = 32'hA5000000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] snap();
        return {in_ready, fields_valid, frame_err, err_code, busy,
                region, auth_level, expiry, signature_id};
    endfunction

    function automatic logic [37:0] expv(input logic rdy, input logic fv, input logic fe,
                                         input logic [1:0] ec, input logic bsy, input logic [31:0] f);
        return {rdy, fv, fe, ec, bsy, f};
    endfunction

    task automatic add(input logic [7:0] d, input logic v, input logic rdy, input logic fv,
                       input logic fe, input logic [1:0] ec, input logic bsy, input logic [31:0] f);
        vec_t r;
        r.d = d; r.v = v; r.rdy = rdy; r.fv = fv; r.fe = fe; r.ec = ec; r.bsy = bsy; r.f = f;
        vecs.push_back(r);
    endtask

    // Drive a byte for one cycle; return 1 ns after the capturing edge.
    task automatic tick(input logic [7:0] d, input logic v);
        in_data  = d;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(snap()), 64'(expv(1, 0, 0, 2'b00, 0, F0)));
        rst_n = 1'b1;

        // Good frame, continuous valid
        add(8'hA5, 1, 1, 0, 0, 2'b00, 1, F0);
        add(8'h0A, 1, 1, 0, 0, 2'b00, 1, F0);
        add(8'h01, 1, 1, 0, 0, 2'b00, 1, F0);
        add(8'h10, 1, 1, 0, 0, 2'b00, 1, F0);
        add(8'hF3, 1, 1, 0, 0, 2'b00, 1, F0);
        add(8'hE8, 1, 0, 1, 0, 2'b00, 1, FA);
        add(8'h00, 0, 1, 0, 0, 2'b00, 0, FA);
        // Bad checksum: error strobe, fields untouched
        add(8'hA5, 1, 1, 0, 0, 2'b00, 1, FA);
        add(8'h0A, 1, 1, 0, 0, 2'b00, 1, FA);
        add(8'h01, 1, 1, 0, 0, 2'b00, 1, FA);
        add(8'h10, 1, 1, 0, 0, 2'b00, 1, FA);
        add(8'hF3, 1, 1, 0, 0, 2'b00, 1, FA);
        add(8'hE9, 1, 1, 0, 1, 2'b01, 0, FA);
        add(8'h00, 0, 1, 0, 0, 2'b01, 0, FA);
        // Garbage in IDLE, then a good frame
        add(8'h00, 1, 1, 0, 0, 2'b01, 0, FA);
        add(8'hFF, 1, 1, 0, 0, 2'b01, 0, FA);
        add(8'h5A, 1, 1, 0, 0, 2'b01, 0, FA);
        add(8'hA5, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h11, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h22, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h33, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h44, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h44, 1, 0, 1, 0, 2'b01, 1, FB);
        add(8'h00, 0, 1, 0, 0, 2'b01, 0, FB);
        // Back-to-back frames; A5 inside a frame is plain data
        add(8'hA5, 1, 1, 0, 0, 2'b01, 1, FB);
        add(8'h0A, 1, 1, 0, 0, 2'b01, 1, FB);
        add(8'h01, 1, 1, 0, 0, 2'b01, 1, FB);
        add(8'h10, 1, 1, 0, 0, 2'b01, 1, FB);
        add(8'hF3, 1, 1, 0, 0, 2'b01, 1, FB);
        add(8'hE8, 1, 0, 1, 0, 2'b01, 1, FA);
        add(8'hA5, 1, 1, 0, 0, 2'b01, 0, FA);
        add(8'hA5, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h55, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h66, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h77, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'h88, 1, 1, 0, 0, 2'b01, 1, FA);
        add(8'hCC, 1, 0, 1, 0, 2'b01, 1, FC);
        add(8'hA5, 1, 1, 0, 0, 2'b01, 0, FC);
        add(8'hA5, 1, 1, 0, 0, 2'b01, 1, FC);
        add(8'hA5, 1, 1, 0, 0, 2'b01, 1, FC);
        add(8'h00, 1, 1, 0, 0, 2'b01, 1, FC);
        add(8'h00, 1, 1, 0, 0, 2'b01, 1, FC);
        add(8'h00, 1, 1, 0, 0, 2'b01, 1, FC);
        add(8'hA5, 1, 0, 1, 0, 2'b01, 1, FD);
        add(8'h00, 0, 1, 0, 0, 2'b01, 0, FD);

        foreach (vecs[i]) begin
            tick(vecs[i].d, vecs[i].v);
            check($sformatf("vec[%0d]", i), 64'(snap()),
                  64'(expv(vecs[i].rdy, vecs[i].fv, vecs[i].fe, vecs[i].ec, vecs[i].bsy, vecs[i].f)));
        end

        // Timeout after A5 0A with TIMEOUT=8 idle cycles
        tick(8'hA5, 1);
        tick(8'h0A, 1);
        for (int i = 1; i <= 7; i++) begin
            tick(8'h00, 0);
            check($sformatf("tmo_wait%0d", i), 64'({frame_err, busy}), 64'(2'b01));
        end
        tick(8'h00, 0);
        check("tmo_abort", 64'(snap()), 64'(expv(1, 0, 1, 2'b10, 0, FD)));
        tick(8'h00, 0);
        check("tmo_after", 64'(snap()), 64'(expv(1, 0, 0, 2'b10, 0, FD)));

        // A transfer on the cycle the count would expire wins; frame completes
        tick(8'hA5, 1);
        repeat (7) tick(8'h00, 0);
        tick(8'h0A, 1);
        check("tmo_boundary_xfer", 64'({frame_err, busy}), 64'(2'b01));
        repeat (7) tick(8'h00, 0);
        check("tmo_boundary_wait", 64'({frame_err, busy}), 64'(2'b01));
        tick(8'h01, 1);
        tick(8'h10, 1);
        tick(8'hF3, 1);
        tick(8'hE8, 1);
        check("tmo_boundary_emit", 64'(snap()), 64'(expv(0, 1, 0, 2'b10, 1, FA)));
        tick(8'h00, 0);

        // Reset in the middle of a frame
        tick(8'hA5, 1);
        tick(8'h0A, 1);
        tick(8'h01, 1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midreset_async", 64'(snap()), 64'(expv(1, 0, 0, 2'b00, 0, F0)));
        tick(8'h00, 0);
        tick(8'h00, 0);
        check("midreset_held", 64'(snap()), 64'(expv(1, 0, 0, 2'b00, 0, F0)));
        rst_n = 1'b1;
        tick(8'hA5, 1);
        tick(8'h0A, 1);
        tick(8'h01, 1);
        tick(8'h10, 1);
        tick(8'hF3, 1);
        check("midreset_nostrobe", 64'({fields_valid, frame_err}), 64'(2'b00));
        tick(8'hE8, 1);
        check("midreset_frame", 64'(snap()), 64'(expv(0, 1, 0, 2'b00, 1, FA)));
        tick(8'h00, 0);
        tick(8'h00, 0);
`ifdef FRAME_STATS_EN
        check("stats_good", 64'(good_count), 64'd1);
        check("stats_bad", 64'(bad_count), 64'd0);
`endif
        check("final_idle", 64'(snap()), 64'(expv(1, 0, 0, 2'b00, 0, FA)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
